// File: rtl/fft_input_frame_loader.sv
// fft_input_frame_loader
//   Collects a valid/ready stream of complex samples into one N-point frame.
//   The frame is presented as flat parallel buses, fft_start is pulsed, and the
//   frame is then frozen until the FFT core raises fft_done.
//   Framing errors against s_last raise frame_err, and the loader
//   resynchronises on the next s_last.
//   Optional macro FFT_LOADER_BITREV_EN: store point k at the bit-reversed slot
//   so the core receives its input in bit-reversed order.
module fft_input_frame_loader #(
    parameter int N     = 16,
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [WIDTH-1:0]     s_real,
    input  logic [WIDTH-1:0]     s_imag,
    input  logic                 s_last,
    output logic                 fft_start,
    input  logic                 fft_done,
    output logic [N*WIDTH-1:0]   frame_real,
    output logic [N*WIDTH-1:0]   frame_imag,
    output logic                 frame_err,
    output logic [15:0]          frame_cnt
);
    localparam int AW = $clog2(N);

    typedef enum logic [1:0] {FILL, SKIP, FIRE, WAIT} state_t;

    state_t                  state;
    logic [AW-1:0]           wr_idx;
    logic                    done_q;
    logic [N-1:0][WIDTH-1:0] re_q;
    logic [N-1:0][WIDTH-1:0] im_q;

    logic                    accept;
    logic                    wr_en;
    logic                    last_slot;
    logic [AW-1:0]           wr_addr;

    // Storage slot for stream position k.
    function automatic logic [AW-1:0] slot_addr(input logic [AW-1:0] k);
`ifdef FFT_LOADER_BITREV_EN
        logic [AW-1:0] r;
        for (int b = 0; b < AW; b++) r[b] = k[AW-1-b];
        return r;
`else
        return k;
`endif
    endfunction

    assign accept     = s_valid & s_ready;
    assign wr_en      = accept & (state == FILL);
    assign last_slot  = (wr_idx == AW'(N - 1));
    assign wr_addr    = slot_addr(wr_idx);
    assign frame_real = re_q;
    assign frame_imag = im_q;

    // Frame storage: only written while filling, so it is frozen through FIRE/WAIT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            re_q <= '0;
            im_q <= '0;
        end else if (wr_en) begin
            re_q[wr_addr] <= s_real;
            im_q[wr_addr] <= s_imag;
        end
    end

    // Control FSM with registered handshake, start, error and frame counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= FILL;
            wr_idx    <= '0;
            s_ready   <= 1'b0;
            fft_start <= 1'b0;
            frame_err <= 1'b0;
            frame_cnt <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q    <= fft_done;
            fft_start <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                FILL: begin
                    s_ready <= 1'b1;
                    if (accept) begin
                        if (last_slot) begin
                            wr_idx <= '0;
                            if (s_last) begin
                                state     <= FIRE;
                                s_ready   <= 1'b0;
                                fft_start <= 1'b1;
                            end else begin
                                // Missing last: drop samples until s_last shows up.
                                frame_err <= 1'b1;
                                state     <= SKIP;
                            end
                        end else if (s_last) begin
                            // Early last: discard the partial frame, refill from slot 0.
                            frame_err <= 1'b1;
                            wr_idx    <= '0;
                        end else begin
                            wr_idx <= wr_idx + AW'(1);
                        end
                    end
                end
                SKIP: begin
                    s_ready <= 1'b1;
                    if (accept && s_last) state <= FILL;
                end
                FIRE: begin
                    s_ready   <= 1'b0;
                    frame_cnt <= frame_cnt + 16'd1;
                    state     <= WAIT;
                end
                WAIT: begin
                    s_ready <= 1'b0;
                    // Only a fresh rise counts; a level held from before is ignored.
                    if (fft_done && !done_q) begin
                        state   <= FILL;
                        s_ready <= 1'b1;
                    end
                end
                default: begin
                    state   <= FILL;
                    s_ready <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fft_input_frame_loader.sv
// Directed bench for fft_input_frame_loader (N=16, WIDTH=16).
module tb_fft_input_frame_loader;
    localparam int N = 16;
    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           s_valid = 1'b0;
    logic           s_last = 1'b0;
    logic           fft_done = 1'b0;
    logic [W-1:0]   s_real = '0;
    logic [W-1:0]   s_imag = '0;
    logic           s_ready, fft_start, frame_err;
    logic [N*W-1:0] frame_real, frame_imag;
    logic [15:0]    frame_cnt;

    int n_total = 0;
    int n_pass = 0;
    int start_cnt = 0;
    int err_cnt = 0;
    int accepts = 0;
    logic [N*W-1:0] er, ei;

    fft_input_frame_loader #(.N(N), .WIDTH(W)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
        .s_real(s_real), .s_imag(s_imag), .s_last(s_last),
        .fft_start(fft_start), .fft_done(fft_done),
        .frame_real(frame_real), .frame_imag(frame_imag),
        .frame_err(frame_err), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (fft_start) start_cnt++;
        if (frame_err) err_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    function automatic int exp_addr(input int k);
`ifdef FFT_LOADER_BITREV_EN
        return {k[0], k[1], k[2], k[3]};
`else
        return k;
`endif
    endfunction

    task automatic build_exp(input int rb, input int ib);
        for (int k = 0; k < N; k++) begin
            er[exp_addr(k)*W +: W] = W'(rb + k);
            ei[exp_addr(k)*W +: W] = W'(ib - k);
        end
    endtask

    // Present one sample and return at the negedge after it is accepted.
    task automatic send(input int re, input int im, input bit last);
        int n = 0;
        while (!s_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            n_total++;
            $display("FAIL send_timeout: s_ready=%0b required 1", s_ready);
        end
        s_valid = 1'b1;
        s_real  = W'(re);
        s_imag  = W'(im);
        s_last  = last;
        @(posedge clk);
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
        accepts++;
    endtask

    task automatic send_frame(input int rb, input int ib);
        for (int k = 0; k < N; k++) send(rb + k, ib - k, k == N - 1);
    endtask

    task automatic do_reset();
        s_valid  = 1'b0;
        s_last   = 1'b0;
        fft_done = 1'b0;
        rst      = 1'b0;
        repeat (2) @(negedge clk);
        rst       = 1'b1;
        start_cnt = 0;
        err_cnt   = 0;
        accepts   = 0;
        @(negedge clk);
    endtask

    // Raise fft_done while in WAIT and check the loader reopens one cycle later.
    task automatic pulse_done();
        n_total++;
        if (s_ready !== 1'b0) $display("FAIL wait_ready: got %0b required 0", s_ready);
        else n_pass++;
        fft_done = 1'b1;
        @(negedge clk);
        n_total++;
        if (s_ready !== 1'b1) $display("FAIL done_exit: s_ready got %0b required 1", s_ready);
        else n_pass++;
        fft_done = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_total++;
        if (s_ready !== 1'b0 || fft_start !== 1'b0 || frame_err !== 1'b0)
            $display("FAIL reset_ctrl: ready=%0b start=%0b err=%0b required 0 0 0",
                     s_ready, fft_start, frame_err);
        else n_pass++;
        n_total++;
        if (frame_cnt !== 16'd0 || frame_real !== '0 || frame_imag !== '0)
            $display("FAIL reset_data: cnt=%0d real=%h imag=%h required zeros",
                     frame_cnt, frame_real, frame_imag);
        else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_total++;
        if (s_ready !== 1'b0) $display("FAIL ready_first: got %0b required 0", s_ready);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (s_ready !== 1'b1) $display("FAIL ready_after: got %0b required 1", s_ready);
        else n_pass++;
    endtask

    task automatic test_natural();
        logic [W-1:0] exp1, exp3, exp15;
        do_reset();
        send_frame(0, 0);
        n_total++;
        if (fft_start !== 1'b1) $display("FAIL start_latency: got %0b required 1", fft_start);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (fft_start !== 1'b0 || frame_cnt !== 16'd1)
            $display("FAIL start_pulse: start=%0b cnt=%0d required 0 1", fft_start, frame_cnt);
        else n_pass++;
        build_exp(0, 0);
        n_total++;
        if (frame_real !== er || frame_imag !== ei)
            $display("FAIL frame1: real=%h imag=%h required %h %h", frame_real, frame_imag, er, ei);
        else n_pass++;
`ifdef FFT_LOADER_BITREV_EN
        exp1 = 16'd8;
        exp3 = 16'd12;
`else
        exp1 = 16'd1;
        exp3 = 16'd3;
`endif
        exp15 = 16'd15;
        n_total++;
        if (frame_real[1*W +: W] !== exp1 || frame_real[3*W +: W] !== exp3 ||
            frame_real[15*W +: W] !== exp15)
            $display("FAIL slot_order: s1=%0d s3=%0d s15=%0d required %0d %0d %0d",
                     frame_real[1*W +: W], frame_real[3*W +: W], frame_real[15*W +: W],
                     exp1, exp3, exp15);
        else n_pass++;
        pulse_done();
        #1;
        n_total++;
        if (start_cnt !== 1 || err_cnt !== 0)
            $display("FAIL natural_counts: starts=%0d errs=%0d required 1 0", start_cnt, err_cnt);
        else n_pass++;
    endtask

    task automatic test_early_last();
        do_reset();
        for (int k = 0; k < 6; k++) send(k + 1, k, k == 5);
        n_total++;
        if (frame_err !== 1'b1) $display("FAIL early_err: got %0b required 1", frame_err);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (frame_err !== 1'b0 || s_ready !== 1'b1)
            $display("FAIL early_recover: err=%0b ready=%0b required 0 1", frame_err, s_ready);
        else n_pass++;
        send_frame(16'h40, 0);
        @(negedge clk);
        #1;
        build_exp(16'h40, 0);
        n_total++;
        if (frame_cnt !== 16'd1 || start_cnt !== 1 || err_cnt !== 1)
            $display("FAIL early_next: cnt=%0d starts=%0d errs=%0d required 1 1 1",
                     frame_cnt, start_cnt, err_cnt);
        else n_pass++;
        n_total++;
        if (frame_real !== er || frame_imag !== ei)
            $display("FAIL early_frame: real=%h required %h", frame_real, er);
        else n_pass++;
        pulse_done();
    endtask

    task automatic test_missing_last();
        do_reset();
        for (int k = 0; k < N; k++) send(k, k, 1'b0);
        for (int k = 0; k < 3; k++) send(16'h7000 + k, 0, k == 2);
        @(negedge clk);
        #1;
        n_total++;
        if (accepts !== 19 || err_cnt !== 1 || start_cnt !== 0 || s_ready !== 1'b1)
            $display("FAIL missing_last: acc=%0d errs=%0d starts=%0d ready=%0b required 19 1 0 1",
                     accepts, err_cnt, start_cnt, s_ready);
        else n_pass++;
        send_frame(16'h100, 16'h200);
        @(negedge clk);
        build_exp(16'h100, 16'h200);
        n_total++;
        if (frame_real !== er || frame_imag !== ei || frame_cnt !== 16'd1)
            $display("FAIL missing_next: cnt=%0d real=%h required 1 %h", frame_cnt, frame_real, er);
        else n_pass++;
        pulse_done();
    endtask

    task automatic test_done_held();
        do_reset();
        fft_done = 1'b1;
        send_frame(100, 16'h7FF0);
        build_exp(100, 16'h7FF0);
        // Junk traffic while not ready must have no effect.
        s_valid = 1'b1;
        s_real  = 16'hDEAD;
        s_imag  = 16'hBEEF;
        s_last  = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c == 2) fft_done = 1'b0;
            n_total++;
            if (s_ready !== 1'b0 || frame_real !== er || frame_imag !== ei)
                $display("FAIL wait_hold c%0d: ready=%0b real=%h required 0 %h",
                         c, s_ready, frame_real, er);
            else n_pass++;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        pulse_done();
        n_total++;
        if (frame_real !== er || frame_cnt !== 16'd1)
            $display("FAIL held_exit: cnt=%0d real=%h required 1 %h", frame_cnt, frame_real, er);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int k = 0; k < 9; k++) send(k + 1, k + 1, 1'b0);
        rst = 1'b0;
        #1;
        n_total++;
        if (s_ready !== 1'b0 || frame_real !== '0 || frame_imag !== '0 || frame_cnt !== 16'd0)
            $display("FAIL rst_fill: ready=%0b cnt=%0d real=%h required 0 0 zeros",
                     s_ready, frame_cnt, frame_real);
        else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        send_frame(16'h20, 16'h30);
        @(negedge clk);
        n_total++;
        if (frame_cnt !== 16'd1) $display("FAIL rst_frame: cnt=%0d required 1", frame_cnt);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_total++;
        if (s_ready !== 1'b0 || fft_start !== 1'b0 || frame_cnt !== 16'd0 || frame_real !== '0)
            $display("FAIL rst_wait: ready=%0b start=%0b cnt=%0d real=%h required 0 0 0 zeros",
                     s_ready, fft_start, frame_cnt, frame_real);
        else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        send_frame(16'h50, 16'h60);
        @(negedge clk);
        #1;
        build_exp(16'h50, 16'h60);
        n_total++;
        if (frame_cnt !== 16'd1 || frame_real !== er || frame_imag !== ei || err_cnt !== 0)
            $display("FAIL rst_after: cnt=%0d errs=%0d real=%h required 1 0 %h",
                     frame_cnt, err_cnt, frame_real, er);
        else n_pass++;
        pulse_done();
    endtask

    initial begin
        test_reset();
        test_natural();
        test_early_last();
        test_missing_last();
        test_done_held();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
